fixed_to_float_conv: RTL and testbench



---
 rtl/fixed_to_float_conv.sv | 148 ++++++++++++++
 tb/tb_fixed_to_float_conv.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float_conv.sv
// Signed fixed-point to IEEE-754 half-precision converter.
// Three-stage pipeline (sign/magnitude, leading-one detect, normalise/round/pack) with valid/ready.
module fixed_to_float_conv #(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] fixed_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [15:0]       float_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              ovf_o,
  output logic              unf_o
);

  localparam int P_W   = $clog2(DATA_W);
  localparam int EXP_W = 16;
  localparam logic signed [EXP_W-1:0] EXP_OFF  = EXP_W'(15 - FRAC_BITS);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W-1:0] EXP_INF  = EXP_W'(31);

  // Global stall: the whole pipe advances only when the output slot is free or draining.
  logic en;
  assign en      = ready_i | ~valid_o;
  assign ready_o = en;

  // ---------------------------------------------------------------- S1
  logic              s1_valid;
  logic              s1_sign;
  logic [DATA_W-1:0] s1_mag;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
    end else if (en) begin
      s1_valid <= valid_i;
      s1_sign  <= fixed_i[DATA_W-1];
      // The most negative input negates to itself, which as unsigned is exactly 2^(DATA_W-1).
      s1_mag   <= fixed_i[DATA_W-1] ? -fixed_i : fixed_i;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [P_W-1:0] lod_p;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    lod_p = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (s1_mag[i]) lod_p = P_W'(i);
    end
  end

  logic              s2_valid;
  logic              s2_sign;
  logic              s2_zero;
  logic [P_W-1:0]    s2_p;
  logic [DATA_W-1:0] s2_mag;

  // NOTE: datapath registers are reset too, so outputs are deterministic straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_p     <= '0;
      s2_mag   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= (s1_mag == '0);
      s2_p     <= lod_p;
      s2_mag   <= s1_mag;
    end
  end

  // ---------------------------------------------------------------- S3
  logic [P_W-1:0]          shamt;
  logic [DATA_W-2:0]       norm_frac;
  logic [9:0]              mant_raw;
  logic                    guard;
  logic                    sticky;
  logic                    round_up;
  logic [10:0]             mant_sum;
  logic signed [EXP_W-1:0] exp_pre;
  logic signed [EXP_W-1:0] exp_post;
  logic                    underflow;
  logic                    overflow;

  // The implicit leading one is shifted out of the top; only the fraction bits are kept.
  assign shamt     = P_W'(DATA_W - 1) - s2_p;
  assign norm_frac = (DATA_W-1)'(s2_mag << shamt);
  assign mant_raw  = norm_frac[DATA_W-2 -: 10];
  assign guard     = norm_frac[DATA_W-12];
  assign sticky    = |norm_frac[DATA_W-13:0];
  assign round_up  = guard & (sticky | mant_raw[0]);
  assign mant_sum  = {1'b0, mant_raw} + {10'b0, round_up};

  assign exp_pre   = $signed(EXP_W'(s2_p)) + EXP_OFF;
  assign exp_post  = exp_pre + $signed({{(EXP_W-1){1'b0}}, mant_sum[10]});

  // Underflow is judged before rounding, overflow after; underflow takes priority so flags are exclusive.
  assign underflow = ~s2_zero & (exp_pre <= EXP_ZERO);
  assign overflow  = ~s2_zero & ~underflow & (exp_post >= EXP_INF);

  logic [15:0] res;
  logic        res_ovf;
  logic        res_unf;

  always_comb begin
    res     = 16'h0000;
    res_ovf = 1'b0;
    res_unf = 1'b0;
    if (s2_zero) begin
      res = 16'h0000;
    end else if (underflow) begin
      res     = {s2_sign, 15'b0};
      res_unf = 1'b1;
    end else if (overflow) begin
      res     = {s2_sign, 5'h1F, 10'h000};
      res_ovf = 1'b1;
    end else begin
      // On a rounding carry mant_sum[9:0] is already zero and exp_post already bumped.
      res = {s2_sign, exp_post[4:0], mant_sum[9:0]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_o <= 1'b0;
      float_o <= 16'h0000;
      ovf_o   <= 1'b0;
      unf_o   <= 1'b0;
    end else if (en) begin
      valid_o <= s2_valid;
      float_o <= res;
      ovf_o   <= res_ovf;
      unf_o   <= res_unf;
    end
  end

endmodule

// File: tb/tb_fixed_to_float_conv.sv
// Scoreboard bench for fixed_to_float_conv: instance 0 uses FRAC_BITS=16, instance 1 uses FRAC_BITS=0.
module tb_fixed_to_float_conv;

  typedef struct {
    logic [15:0] f;
    logic        ovf;
    logic        unf;
    int          t;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] fixed   [2];
  logic        valid_i [2];
  logic        ready_o [2];
  logic [15:0] float_o [2];
  logic        valid_o [2];
  logic        ready_i [2];
  logic        ovf_o   [2];
  logic        unf_o   [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit          stalled [2] = '{1'b0, 1'b0};
  logic [17:0] held    [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_to_float_conv #(.DATA_W(32), .FRAC_BITS(16)) u_f16 (
    .clk(clk), .reset_n(reset_n), .fixed_i(fixed[0]), .valid_i(valid_i[0]), .ready_o(ready_o[0]),
    .float_o(float_o[0]), .valid_o(valid_o[0]), .ready_i(ready_i[0]), .ovf_o(ovf_o[0]), .unf_o(unf_o[0])
  );

  fixed_to_float_conv #(.DATA_W(32), .FRAC_BITS(0)) u_f0 (
    .clk(clk), .reset_n(reset_n), .fixed_i(fixed[1]), .valid_i(valid_i[1]), .ready_o(ready_o[1]),
    .float_o(float_o[1]), .valid_o(valid_o[1]), .ready_i(ready_i[1]), .ovf_o(ovf_o[1]), .unf_o(unf_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one word at a negedge; hold it until accepted, then queue the expected result.
  task automatic send(input int s, input logic [31:0] d, input logic [15:0] f,
                      input logic ovf, input logic unf, input bit push, input bit lat);
    bit   acc = 1'b0;
    exp_t e;
    @(negedge clk);
    fixed[s]   = d;
    valid_i[s] = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      #1;
      acc = ready_o[s];
      e.t = cyc;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    if (!acc) check($sformatf("send_timeout%0d", s), 32'd0, 32'd1);
    else if (push) begin
      e.f   = f;
      e.ovf = ovf;
      e.unf = unf;
      e.lat = lat;
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic idle(input int s);
    @(negedge clk);
    valid_i[s] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clk);
    @(negedge clk);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
  endtask

  task automatic mon(input int s);
    exp_t e;
    int   qs;
    if (!reset_n) begin
      stalled[s] = 1'b0;
      return;
    end
    if (valid_o[s] && ready_i[s]) begin
      qs = (s == 0) ? q0.size() : q1.size();
      if (qs == 0) check($sformatf("unexpected_out%0d", s), {16'h0, float_o[s]}, 32'hFFFF_FFFF);
      else begin
        if (s == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("float%0d", s), float_o[s], e.f);
        check($sformatf("ovf%0d", s), ovf_o[s], e.ovf);
        check($sformatf("unf%0d", s), unf_o[s], e.unf);
        if (e.lat) check($sformatf("latency%0d", s), cyc - e.t, 3);
      end
    end
    if (valid_o[s] && !ready_i[s]) begin
      check($sformatf("ready_o_stall%0d", s), ready_o[s], 0);
      if (stalled[s]) check($sformatf("hold%0d", s), {ovf_o[s], unf_o[s], float_o[s]}, held[s]);
      held[s]    = {ovf_o[s], unf_o[s], float_o[s]};
      stalled[s] = 1'b1;
    end else begin
      stalled[s] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    #2;
    mon(0);
    mon(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [15:0] bp_exp [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                              16'h4500, 16'h4600, 16'h4700, 16'h4800};

  initial begin
    reset_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      fixed[s]   = '0;
      valid_i[s] = 1'b0;
      ready_i[s] = 1'b1;
    end
    #12;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_valid%0d", s), valid_o[s], 0);
      check($sformatf("rst_float%0d", s), float_o[s], 0);
      check($sformatf("rst_ovf%0d", s), ovf_o[s], 0);
      check($sformatf("rst_unf%0d", s), unf_o[s], 0);
      check($sformatf("rst_ready%0d", s), ready_o[s], 1);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // FRAC_BITS = 16: basics, extremes, ties, underflow (back-to-back, latency checked)
    send(0, 32'h0001_0000, 16'h3C00, 0, 0, 1, 1);
    send(0, 32'hFFFF_0000, 16'hBC00, 0, 0, 1, 1);
    send(0, 32'h0000_0000, 16'h0000, 0, 0, 1, 1);
    send(0, 32'h8000_0000, 16'hF800, 0, 0, 1, 1);
    send(0, 32'h7FFF_FFFF, 16'h7800, 0, 0, 1, 1);
    send(0, 32'h0000_0004, 16'h0400, 0, 0, 1, 1);
    send(0, 32'h0001_0020, 16'h3C00, 0, 0, 1, 1);
    send(0, 32'h0001_0060, 16'h3C02, 0, 0, 1, 1);
    send(0, 32'h0001_0021, 16'h3C01, 0, 0, 1, 1);
    send(0, 32'h0000_0001, 16'h0000, 0, 1, 1, 1);
    send(0, 32'hFFFF_FFFF, 16'h8000, 0, 1, 1, 1);
    idle(0);

    // FRAC_BITS = 0: largest finite, rounding into infinity, negative overflow
    send(1, 32'd65504,     16'h7BFF, 0, 0, 1, 1);
    send(1, 32'd65520,     16'h7C00, 1, 0, 1, 1);
    send(1, 32'hFFFF_0000, 16'hFC00, 1, 0, 1, 1);
    send(1, 32'd1,         16'h3C00, 0, 0, 1, 1);
    idle(1);
    drain();

    // Backpressure: 1.0..8.0 streamed, ready_i low for 5 cycles mid-stream
    fork
      begin
        for (int k = 1; k <= 8; k++) send(0, 32'(k) << 16, bp_exp[k-1], 0, 0, 1, 0);
        idle(0);
      end
      begin
        repeat (4) @(negedge clk);
        ready_i[0] = 1'b0;
        repeat (5) @(negedge clk);
        ready_i[0] = 1'b1;
      end
    join
    drain();

    // Reset with three results in flight
    @(negedge clk);
    ready_i[0] = 1'b0;
    send(0, 32'h0003_0000, 16'h0000, 0, 0, 0, 0);
    send(0, 32'h0004_0000, 16'h0000, 0, 0, 0, 0);
    send(0, 32'h0005_0000, 16'h0000, 0, 0, 0, 0);
    idle(0);
    check("inflight_valid", valid_o[0], 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_o[0], 0);
    check("mid_rst_float", float_o[0], 0);
    @(negedge clk);
    ready_i[0] = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    send(0, 32'h0002_0000, 16'h4000, 0, 0, 1, 1);
    idle(0);
    drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
